// File: rtl/keypad_entry.sv
// Keypad digit entry: collects packed BCD from debounced key presses and, on Enter,
// converts it to binary and offers it on a valid/ready handshake.
module keypad_entry #(
  parameter int MAX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  in_key,
  output logic [31:0] entry,
  output logic [3:0]  digits,
  output logic        full,
  output logic        busy,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);
  typedef enum logic [1:0] {EDIT, CONV, DONE} state_t;

  localparam logic [3:0] MAXD = 4'(MAX_DIGITS);
  localparam logic [2:0] TOP  = 3'(MAX_DIGITS - 1);

  state_t      state;
  logic        prev_held;
  logic [31:0] acc;
  logic [2:0]  idx;

  logic        press;
  logic [3:0]  code;
  logic [3:0]  nib;
  logic [31:0] acc_next;

  assign press    = in_key[4] & ~prev_held;
  assign code     = in_key[3:0];
  assign nib      = entry[{idx, 2'b00} +: 4];
  // acc*10 + nibble, written as shifts to keep it a pair of adders
  assign acc_next = (acc << 3) + (acc << 1) + {28'h0, nib};
  assign full     = (digits == MAXD);
  assign busy     = (state != EDIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EDIT;
      prev_held <= 1'b0;
      entry     <= '0;
      digits    <= '0;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      prev_held <= in_key[4];
      case (state)
        EDIT: if (press) begin
          if (code <= 4'd9) begin
            if (digits < MAXD) begin
              entry  <= {entry[27:0], code};
              digits <= digits + 4'd1;
            end
          end else if (code == 4'hA) begin
            if (digits != 4'd0) begin
              entry  <= {4'h0, entry[31:4]};
              digits <= digits - 4'd1;
            end
          end else if (code == 4'hB) begin
            entry  <= '0;
            digits <= '0;
          end else if (code == 4'hC && digits != 4'd0) begin
            acc   <= '0;
            idx   <= TOP;
            state <= CONV;
          end
        end
        // All nibbles are walked; unused upper ones are zero and add nothing.
        CONV: begin
          acc <= acc_next;
          idx <= idx - 3'd1;
          if (idx == 3'd0) begin
            out_data  <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          entry     <= '0;
          digits    <= '0;
          out_valid <= 1'b0;
          state     <= EDIT;
        end
        default: state <= EDIT;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed steps plus random key streams against a
// digit-list model (entry packed from the list, value by decimal accumulation).
module tb_keypad_entry;
  localparam int MAXD = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  in_key = '0;
  logic [31:0] entry;
  logic [3:0]  digits;
  logic        full, busy, out_valid, out_ready = 1'b0;
  logic [31:0] out_data;

  int checks = 0;
  int passes = 0;
  int q[$];        // typed digits, oldest first
  bit frozen = 0;  // model: DUT is in CONV/DONE, presses ignored

  keypad_entry #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk), .reset(reset), .in_key(in_key), .entry(entry), .digits(digits),
    .full(full), .busy(busy), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_entry();
    logic [31:0] e = 0;
    foreach (q[i]) e = (e << 4) | 32'(q[i]);
    return e;
  endfunction

  function automatic logic [31:0] m_value();
    logic [31:0] v = 0;
    foreach (q[i]) v = v * 10 + 32'(q[i]);
    return v;
  endfunction

  task automatic chk_entry(input string tag);
    chk({tag, ".entry"}, entry, m_entry());
    chk({tag, ".digits"}, {28'h0, digits}, q.size());
    chk({tag, ".full"}, {31'h0, full}, q.size() == MAXD);
  endtask

  // One-cycle press then one-cycle release; Enter with digits goes to commit.
  task automatic press(input logic [3:0] code);
    in_key = {1'b1, code};
    tick();
    if (!frozen) begin
      if (code <= 9) begin
        if (q.size() < MAXD) q.push_back(int'(code));
      end else if (code == 4'hA) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (code == 4'hB) q.delete();
    end
    chk_entry("press");
    if (code == 4'hC && !frozen) chk("enter_empty.busy", {31'h0, busy}, 0);
    in_key = {1'b0, code};
    tick();
  endtask

  task automatic commit(input bit late_ready, input int wait_cyc);
    logic [31:0] v;
    int cnt;
    v = m_value();
    out_ready = !late_ready;
    in_key = {1'b1, 4'hC};
    tick();
    in_key = {1'b0, 4'hC};
    frozen = 1;
    chk("commit.busy", {31'h0, busy}, 1);
    cnt = 1;
    while (!out_valid && cnt < 30) begin
      tick();
      cnt++;
    end
    chk("commit.latency", cnt, MAXD + 1);
    chk("commit.data", out_data, v);
    chk("commit.frozen_entry", entry, m_entry());
    if (late_ready) begin
      for (int k = 0; k < wait_cyc; k++) begin
        press(4'($urandom_range(0, 9)));
        chk("wait.valid", {31'h0, out_valid}, 1);
        chk("wait.data", out_data, v);
      end
      out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b0;
    frozen = 0;
    q.delete();
    chk("accept.valid", {31'h0, out_valid}, 0);
    chk("accept.busy", {31'h0, busy}, 0);
    chk_entry("accept");
  endtask

  task automatic key(input logic [3:0] code);
    if (code == 4'hC && q.size() > 0) commit($urandom_range(0, 1), $urandom_range(0, 6));
    else press(code);
  endtask

  initial begin
    logic [3:0] c;
    int r;
    bit seen;
    // reset state
    tick(); tick();
    chk("rst.entry", entry, 0);
    chk("rst.digits", {28'h0, digits}, 0);
    chk("rst.full", {31'h0, full}, 0);
    chk("rst.busy", {31'h0, busy}, 0);
    chk("rst.valid", {31'h0, out_valid}, 0);
    chk("rst.data", out_data, 0);
    reset = 1'b0;
    tick();

    // 1,2,3 then Enter with ready already high: 123 = 0x7B
    key(4'd1); key(4'd2); key(4'd3);
    chk("t1.entry", entry, 32'h123);
    commit(0, 0);

    // nine 9s -> full, ninth ignored
    repeat (9) key(4'd9);
    chk("t2.entry", entry, 32'h99999999);
    chk("t2.full", {31'h0, full}, 1);
    commit(0, 0);

    // edit keys
    key(4'd4); key(4'd5); key(4'd6); key(4'hA); key(4'd7);
    chk("t3.entry", entry, 32'h457);
    key(4'hB);
    key(4'hC);
    key(4'hA);

    // long hold with a code change mid-hold counts once
    in_key = {1'b1, 4'd5};
    repeat (25) tick();
    in_key = {1'b1, 4'd6};
    repeat (25) tick();
    in_key = 5'h0;
    tick();
    q.push_back(5);
    chk_entry("hold");
    key(4'hE); key(4'hD); key(4'hF);
    key(4'hB);

    // 42 held off by out_ready low, presses during the wait ignored
    key(4'd4); key(4'd2);
    commit(1, 10);

    // reset three cycles into CONV
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    in_key = {1'b1, 4'hC};
    tick();
    in_key = 5'h0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    q.delete();
    chk_entry("abort");
    chk("abort.busy", {31'h0, busy}, 0);
    chk("abort.valid", {31'h0, out_valid}, 0);
    chk("abort.data", out_data, 0);
    reset = 1'b0;
    seen = 0;
    repeat (15) begin
      tick();
      seen |= out_valid;
    end
    chk("abort.never_valid", {31'h0, seen}, 0);

    // random key stream
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 21);
      c = (r < 16) ? 4'(r) : (r < 18) ? 4'hC : 4'($urandom_range(0, 9));
      key(c);
    end
    if (q.size() > 0) commit(1, 2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/keypad_entry.md
# keypad_entry

Consumes the debounced key stream produced by the keypad scanner and turns it into committed 32-bit operands for the `brain` core. Digits are collected as packed BCD, shown live for the 7-segment tube, and on Enter converted to binary. The result is offered to the consumer on a valid/ready handshake. Sits between `keypad` and `brain` inside `hardware_top`.

## Interface
- MAX_DIGITS, 8, maximum decimal digits held; 1..8, so the BCD buffer fits 32 bits and 99,999,999 < 2^32.
- clk  input  1  system clock; the single clock for the block.
- reset  input  1  synchronous, active-high; the already-debounced top-level reset.
- in_key  input  5  from keypad; bit4 = key held, bits3:0 = key code.
- entry  output  32  packed BCD of the digits typed so far; digit 0 is in [3:0], unused nibbles are 0; drives the tube.
- digits  output  4  number of digits currently held, 0..MAX_DIGITS.
- full  output  1  high when digits == MAX_DIGITS.
- busy  output  1  high in CONV or DONE.
- out_valid  output  1  committed operand available.
- out_data  output  32  binary value of the committed entry; stable while out_valid is high.
- out_ready  input  1  consumer accepts out_data.

## Operation
- Key code map: 0x0–0x9 are digits, 0xA is backspace, 0xB is clear, 0xC is enter. Codes 0xD–0xF are ignored.
- Press event: `in_key[4]==1` while the registered previous value of bit4 is 0.
  - Holding a key never repeats.
  - A code change while bit4 stays high is not an event.
  - The previous-bit4 register updates every cycle, in every state.
- States are EDIT, CONV and DONE. Reset enters EDIT.
- EDIT, on each press event:
  - Digit d with digits < MAX_DIGITS: entry <= {entry[27:0], d}, digits+1.
  - Digit d with full: ignored, no state change.
  - Backspace with digits > 0: entry <= {4'h0, entry[31:4]}, digits−1. With digits == 0 it is a no-op.
  - Clear: entry <= 0, digits <= 0.
  - Enter with digits > 0: acc <= 0, nibble index i <= MAX_DIGITS−1, go to CONV. Enter with digits == 0 is ignored.
- CONV, one cycle per nibble from most significant to least:
  - acc <= (acc<<3) + (acc<<1) + entry[4i+3:4i]; i decrements.
  - Leading zero nibbles are harmless, so all MAX_DIGITS nibbles are processed regardless of digits.
  - After the i==0 step: out_data <= final acc, out_valid <= 1, go to DONE.
- DONE: holds out_valid and out_data until out_valid & out_ready. On that cycle the next state clears entry, digits and out_valid and returns to EDIT.
- entry and digits are frozen during CONV and DONE, so the tube keeps showing the committed number.
- Press events in CONV and DONE are discarded, including one coinciding with the accepting handshake. They are not queued.
- out_ready is ignored outside DONE.
- Arithmetic is 32-bit unsigned. No overflow is possible given the MAX_DIGITS ≤ 8 bound.

## Timing
- Reset values: entry 0, digits 0, full 0, busy 0, out_valid 0, out_data 0, acc 0, previous-bit4 0, state EDIT.
- Reset asserted mid-CONV or mid-DONE aborts on the next edge. No out_valid is produced.
- A press event sampled at edge n updates entry, digits and full after edge n, visible in cycle n+1.
- Enter sampled at edge n:
  - busy = 1 from cycle n+1.
  - out_valid = 1 from cycle n+1+MAX_DIGITS, i.e. cycle n+9 with the default.
- Handshake completes at edge m when out_valid & out_ready. From cycle m+1: out_valid = 0, busy = 0, entry = 0, digits = 0.
- If out_ready is already high when out_valid rises, out_valid is high for exactly one cycle.
- Minimum spacing between commits: MAX_DIGITS + 2 cycles plus typing time.

## Test plan
- Reset, then press 1,2,3 (each 1 cycle held, with gaps) -> entry = 0x00000123, digits = 3. Enter with out_ready = 1 -> out_valid pulses exactly 9 cycles after Enter with out_data = 123 (0x7B), then entry = 0.
- Press 9 eight times, then a ninth 9 -> full = 1 and entry = 0x99999999. Enter -> out_data = 99,999,999 (0x05F5E0FF).
- Type 4,5,6, backspace, 7 -> entry = 0x457. Clear -> entry = 0, digits = 0. Enter at digits = 0 -> busy stays 0.
- Hold key 5 for 50 cycles, switching code to 6 mid-hold -> exactly one digit 5 entered. Key 0xE press -> no change.
- Commit 42 with out_ready = 0 for 20 cycles -> out_valid and out_data = 42 stable, and digit presses during the wait are ignored. Raise out_ready -> one-cycle accept, return to EDIT with entry = 0.
- Assert reset 3 cycles into CONV -> all outputs 0 next cycle, and out_valid is never asserted for that entry.
